// File: rtl/ttt_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : ttt_move_sequencer
// Brief    : Debounces the next/confirm push-buttons, walks a cursor over
//            cells 1..9 and issues one-cycle move strobes (playX/playO) to
//            the tic-tac-toe game. After each strobe it waits for the game to
//            mark the cell. The block stops for good once the game reports an
//            end (until rst).
// Options  : TTT_AUTOSKIP_EN - cursor skips occupied cells on next, and
//            advances to the next empty cell after an acknowledged move.
// Revision : 1.0 - initial release
// ============================================================================
module ttt_move_sequencer #(
  parameter int DEB_CYCLES   = 4,
  parameter int ACK_TIMEOUT  = 16,
  parameter int FIRST_PLAYER = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        btn_next,
  input  logic        btn_confirm,
  input  logic [17:0] board,
  input  logic [1:0]  who,
  output logic        playX,
  output logic        playO,
  output logic [3:0]  playerX_position,
  output logic [3:0]  playerO_position,
  output logic [3:0]  cursor,
  output logic        turn,
  output logic        err_occupied,
  output logic        err_timeout,
  output logic        game_over
);

  localparam int DEB_W = $clog2(DEB_CYCLES + 1);
  localparam int TMR_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [DEB_W-1:0] c_deb_last   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [TMR_W-1:0] c_tmr_last   = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic             c_first_turn = (FIRST_PLAYER != 0);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_setup = 3'd1;
  localparam logic [2:0] c_st_pulse = 3'd2;
  localparam logic [2:0] c_st_wait  = 3'd3;
  localparam logic [2:0] c_st_over  = 3'd4;

  // Two-bit content of cell idx (1..9); out-of-range cells read as empty.
  function automatic logic [1:0] cell_at(input logic [17:0] b, input logic [3:0] idx);
    logic [1:0] r;
    r = 2'b00;
    for (int i = 1; i <= 9; i++) begin
      if (idx == 4'(i)) r = b[2*i-2 +: 2];
    end
    return r;
  endfunction

`ifdef TTT_AUTOSKIP_EN
  // First empty cell after cur, wrapping 9 -> 1; cur itself if none is free.
  function automatic logic [3:0] next_empty(input logic [17:0] b, input logic [3:0] cur);
    logic [3:0] r;
    logic [3:0] c;
    logic       found;
    r     = cur;
    c     = cur;
    found = 1'b0;
    for (int k = 0; k < 8; k++) begin
      c = (c >= 4'd9) ? 4'd1 : c + 4'd1;
      if (!found && (cell_at(b, c) == 2'b00)) begin
        r     = c;
        found = 1'b1;
      end
    end
    return r;
  endfunction
`endif

  // --------------------------------------------------------------------------
  // Button debouncers: bit 0 = next, bit 1 = confirm
  // --------------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] btn_rise;

  assign btn_raw = {btn_confirm, btn_next};

  for (genvar gi = 0; gi < 2; gi++) begin : g_deb
    logic [DEB_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             rise_q, rise_d;

    // Count consecutive raw samples disagreeing with the level; flip on the last one
    always_comb begin
      cnt_d   = '0;
      level_d = level_q;
      if (btn_raw[gi] != level_q) begin
        if (cnt_q == c_deb_last) level_d = btn_raw[gi];
        else                     cnt_d   = cnt_q + 1'b1;
      end
      rise_d = level_d & ~level_q;
    end

    // Debounce state registers
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_q   <= '0;
        level_q <= 1'b0;
        rise_q  <= 1'b0;
      end else begin
        cnt_q   <= cnt_d;
        level_q <= level_d;
        rise_q  <= rise_d;
      end
    end

    assign btn_rise[gi] = rise_q;
  end

  // --------------------------------------------------------------------------
  // Move FSM and datapath
  // --------------------------------------------------------------------------
  logic [2:0]       state_q, state_d;
  logic [3:0]       cursor_q, cursor_d;
  logic             turn_q, turn_d;
  logic [3:0]       xpos_q, xpos_d;
  logic [3:0]       opos_q, opos_d;
  logic             err_occ_q, err_occ_d;
  logic             err_to_q, err_to_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic       w_next_rise;
  logic       w_conf_rise;
  logic       w_game_end;
  logic       w_cur_empty;
  logic [3:0] w_move_cell;
  logic       w_acked;
  logic [3:0] w_cursor_next;

  assign w_next_rise = btn_rise[0];
  assign w_conf_rise = btn_rise[1];
  assign w_game_end  = (who != 2'b00);
  assign w_cur_empty = (cell_at(board, cursor_q) == 2'b00);
  // Only the active side's position is non-zero while a move is in flight.
  assign w_move_cell = xpos_q | opos_q;
  assign w_acked     = (cell_at(board, w_move_cell) != 2'b00);

`ifdef TTT_AUTOSKIP_EN
  assign w_cursor_next = next_empty(board, cursor_q);
`else
  assign w_cursor_next = (cursor_q == 4'd9) ? 4'd1 : cursor_q + 4'd1;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= c_st_idle;
    else     state_q <= state_d;
  end

  // Next-state logic; a reported game end overrides everything
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_st_idle:  if (w_conf_rise && w_cur_empty) state_d = c_st_setup;
      c_st_setup: state_d = c_st_pulse;
      c_st_pulse: state_d = c_st_wait;
      c_st_wait:  if (w_acked || (timer_q == c_tmr_last)) state_d = c_st_idle;
      c_st_over:  state_d = c_st_over;
      default:    state_d = c_st_idle;
    endcase
    if (w_game_end) state_d = c_st_over;
  end

  // Datapath next values: cursor, turn, latched positions, error pulses, ack timer
  always_comb begin
    cursor_d  = cursor_q;
    turn_d    = turn_q;
    xpos_d    = xpos_q;
    opos_d    = opos_q;
    err_occ_d = 1'b0;
    err_to_d  = 1'b0;
    timer_d   = '0;
    if (w_game_end || (state_q == c_st_over)) begin
      xpos_d = 4'd0;
      opos_d = 4'd0;
    end else begin
      case (state_q)
        c_st_idle: begin
          // Position is latched on entry so it is already valid during SETUP.
          if (w_conf_rise) begin
            if (w_cur_empty) begin
              if (turn_q) opos_d = cursor_q;
              else        xpos_d = cursor_q;
            end else begin
              err_occ_d = 1'b1;
            end
          end else if (w_next_rise) begin
            cursor_d = w_cursor_next;
          end
        end
        c_st_wait: begin
          timer_d = timer_q + 1'b1;
          if (w_acked) begin
            turn_d = ~turn_q;
            xpos_d = 4'd0;
            opos_d = 4'd0;
`ifdef TTT_AUTOSKIP_EN
            cursor_d = next_empty(board, cursor_q);
`endif
          end else if (timer_q == c_tmr_last) begin
            err_to_d = 1'b1;
            xpos_d   = 4'd0;
            opos_d   = 4'd0;
          end
        end
        default: ;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cursor_q  <= 4'd1;
      turn_q    <= c_first_turn;
      xpos_q    <= 4'd0;
      opos_q    <= 4'd0;
      err_occ_q <= 1'b0;
      err_to_q  <= 1'b0;
      timer_q   <= '0;
    end else begin
      cursor_q  <= cursor_d;
      turn_q    <= turn_d;
      xpos_q    <= xpos_d;
      opos_q    <= opos_d;
      err_occ_q <= err_occ_d;
      err_to_q  <= err_to_d;
      timer_q   <= timer_d;
    end
  end

  // Output decode: strobes exist only in PULSE, so X and O can never coincide
  always_comb begin
    playX     = (state_q == c_st_pulse) & ~turn_q;
    playO     = (state_q == c_st_pulse) &  turn_q;
    game_over = (state_q == c_st_over);
  end

  assign playerX_position = xpos_q;
  assign playerO_position = opos_q;
  assign cursor           = cursor_q;
  assign turn             = turn_q;
  assign err_occupied     = err_occ_q;
  assign err_timeout      = err_to_q;

endmodule
`default_nettype wire

// File: tb/tb_ttt_move_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_ttt_move_sequencer
// Brief    : Self-checking bench for ttt_move_sequencer. A move-level model
//            (sample history, move age counter) predicts every output on
//            every cycle; directed literal checks pin the model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ttt_move_sequencer;

  localparam int DEB_CYCLES   = 4;
  localparam int ACK_TIMEOUT  = 16;
  localparam int FIRST_PLAYER = 0;

  logic        clk;
  logic        rst;
  logic        btn_next;
  logic        btn_confirm;
  logic [17:0] board;
  logic [1:0]  who;
  logic        playX;
  logic        playO;
  logic [3:0]  playerX_position;
  logic [3:0]  playerO_position;
  logic [3:0]  cursor;
  logic        turn;
  logic        err_occupied;
  logic        err_timeout;
  logic        game_over;

  ttt_move_sequencer #(
    .DEB_CYCLES  (DEB_CYCLES),
    .ACK_TIMEOUT (ACK_TIMEOUT),
    .FIRST_PLAYER(FIRST_PLAYER)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .btn_next        (btn_next),
    .btn_confirm     (btn_confirm),
    .board           (board),
    .who             (who),
    .playX           (playX),
    .playO           (playO),
    .playerX_position(playerX_position),
    .playerO_position(playerO_position),
    .cursor          (cursor),
    .turn            (turn),
    .err_occupied    (err_occupied),
    .err_timeout     (err_timeout),
    .game_over       (game_over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Behavioural model: a move is "in flight" with an age in cycles since it
  // was accepted; age 1 = position shown, age 2 = strobe, age >= 3 = waiting.
  // --------------------------------------------------------------------------
  int                  m_cursor;
  logic                m_turn;
  logic                m_over;
  logic                m_err_occ;
  logic                m_err_to;
  logic                m_active;
  int                  m_age;
  int                  m_cell;
  logic                m_side;
  logic [DEB_CYCLES-1:0] m_hist [2];
  logic [1:0]          m_lvl;
  logic [1:0]          m_ev;

  function automatic int mcell(input logic [17:0] b, input int c);
    return int'((b >> (2 * (c - 1))) & 18'h3);
  endfunction

  function automatic int next_free(input logic [17:0] b, input int c);
    int n;
    for (int k = 1; k <= 8; k++) begin
      n = ((c - 1 + k) % 9) + 1;
      if (mcell(b, n) == 0) return n;
    end
    return c;
  endfunction

  task automatic m_reset();
    m_cursor  = 1;
    m_turn    = (FIRST_PLAYER != 0);
    m_over    = 1'b0;
    m_err_occ = 1'b0;
    m_err_to  = 1'b0;
    m_active  = 1'b0;
    m_age     = 0;
    m_cell    = 0;
    m_side    = 1'b0;
    m_hist[0] = '0;
    m_hist[1] = '0;
    m_lvl     = 2'b00;
    m_ev      = 2'b00;
  endtask

  task automatic m_step();
    logic       ev_n, ev_c;
    logic [1:0] raw;
    ev_n      = m_ev[0];
    ev_c      = m_ev[1];
    m_err_occ = 1'b0;
    m_err_to  = 1'b0;
    if (m_over) begin
      // frozen until reset
    end else if (who != 2'b00) begin
      m_over   = 1'b1;
      m_active = 1'b0;
    end else if (m_active) begin
      if (m_age >= 3 && mcell(board, m_cell) != 0) begin
        m_active = 1'b0;
        m_turn   = ~m_turn;
`ifdef TTT_AUTOSKIP_EN
        m_cursor = next_free(board, m_cursor);
`endif
      end else if (m_age == 2 + ACK_TIMEOUT) begin
        m_active = 1'b0;
        m_err_to = 1'b1;
      end else begin
        m_age++;
      end
    end else if (ev_c) begin
      if (mcell(board, m_cursor) == 0) begin
        m_active = 1'b1;
        m_age    = 1;
        m_cell   = m_cursor;
        m_side   = m_turn;
      end else begin
        m_err_occ = 1'b1;
      end
    end else if (ev_n) begin
`ifdef TTT_AUTOSKIP_EN
      m_cursor = next_free(board, m_cursor);
`else
      m_cursor = (m_cursor % 9) + 1;
`endif
    end
    // A debounced level flips once the last DEB_CYCLES samples all oppose it.
    raw  = {btn_confirm, btn_next};
    m_ev = 2'b00;
    for (int b = 0; b < 2; b++) begin
      m_hist[b] = {m_hist[b][DEB_CYCLES-2:0], raw[b]};
      if (!m_lvl[b] && (&m_hist[b])) begin
        m_lvl[b] = 1'b1;
        m_ev[b]  = 1'b1;
      end else if (m_lvl[b] && (m_hist[b] == '0)) begin
        m_lvl[b] = 1'b0;
      end
    end
  endtask

  function automatic logic [17:0] model_vec();
    logic       px, po;
    logic [3:0] xp, op;
    px = m_active && (m_age == 2) && !m_side;
    po = m_active && (m_age == 2) &&  m_side;
    xp = (m_active && !m_side) ? 4'(m_cell) : 4'd0;
    op = (m_active &&  m_side) ? 4'(m_cell) : 4'd0;
    return {px, po, xp, op, 4'(m_cursor), m_turn, m_err_occ, m_err_to, m_over};
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else     m_step();
    end
  end

  // --------------------------------------------------------------------------
  // Checking and stimulus
  // --------------------------------------------------------------------------
  int n_cmp;
  int n_bad;
  int seen_x, seen_o, seen_eo, seen_et;
  bit done;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_loop();
    logic [17:0] act, exp;
    while (!done) begin
      @(negedge clk);
      act = {playX, playO, playerX_position, playerO_position, cursor, turn,
             err_occupied, err_timeout, game_over};
      exp = model_vec();
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL outputs actual=%h expected=%h @%0t", act, exp, $time);
      end
      if (playX)        seen_x++;
      if (playO)        seen_o++;
      if (err_occupied) seen_eo++;
      if (err_timeout)  seen_et++;
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_next();
    btn_next = 1'b1;
    cyc(DEB_CYCLES + 1);
    btn_next = 1'b0;
    cyc(DEB_CYCLES + 2);
  endtask

  task automatic press_conf();
    btn_confirm = 1'b1;
    cyc(DEB_CYCLES + 1);
    btn_confirm = 1'b0;
    cyc(DEB_CYCLES + 2);
  endtask

  task automatic stimulus();
    int bx, bo, be, bt, cur;
    rst = 1'b1; btn_next = 1'b0; btn_confirm = 1'b0; board = '0; who = 2'b00;
    cyc(3);
    check("reset_cursor", int'(cursor), 1);
    check("reset_turn", int'(turn), FIRST_PLAYER);
    check("reset_pos", int'({playerX_position, playerO_position}), 0);
    check("reset_over", int'(game_over), 0);
    rst = 1'b0;
    cyc(2);

    // Glitch shorter than the debounce window
    bx = seen_x + seen_o; be = seen_eo + seen_et;
    btn_confirm = 1'b1; cyc(DEB_CYCLES - 1); btn_confirm = 1'b0; cyc(8);
    check("glitch_strobe", seen_x + seen_o - bx, 0);
    check("glitch_err", seen_eo + seen_et - be, 0);

    // Three next presses: 1 -> 4
    repeat (3) press_next();
    check("next_cursor4", int'(cursor), 4);

    // Confirm at 4: position one cycle after the edge, strobe the cycle after
    btn_confirm = 1'b1;
    cyc(5);
    check("lat_pos_t1", int'(playerX_position), 4);
    check("lat_strobe_t1", int'(playX), 0);
    cyc(1);
    check("lat_strobe_t2", int'(playX), 1);
    check("lat_no_playO", int'(playO), 0);
    cyc(1);
    check("lat_strobe_t3", int'(playX), 0);
    board[7:6] = 2'b01;
    cyc(1);
    check("ack_turn", int'(turn), 1);
    check("ack_pos", int'(playerX_position), 0);
    btn_confirm = 1'b0;
    cyc(DEB_CYCLES + 2);

`ifndef TTT_AUTOSKIP_EN
    // Confirm on the occupied cell 4
    be = seen_eo; bx = seen_x + seen_o;
    press_conf();
    check("occ_pulse", seen_eo - be, 1);
    check("occ_turn", int'(turn), 1);
    check("occ_no_strobe", seen_x + seen_o - bx, 0);
    press_next();
`endif
    check("cursor5", int'(cursor), 5);

    // Confirm at 5, game never marks the cell
    bt = seen_et;
    press_conf();
    check("to_pos_held", int'(playerO_position), 5);
    check("to_x_idle", int'(playerX_position), 0);
    cyc(20);
    check("to_pulse", seen_et - bt, 1);
    check("to_pos_clear", int'(playerO_position), 0);
    check("to_turn", int'(turn), 1);

    // Wrap 9 -> 1
    repeat (4) press_next();
    check("wrap_cursor9", int'(cursor), 9);
    press_next();
    check("wrap_cursor1", int'(cursor), 1);

    // Next and confirm together: confirm wins
    bx = seen_x; bo = seen_o;
    btn_next = 1'b1; btn_confirm = 1'b1;
    cyc(5);
    check("sim_pos", int'(playerO_position), 1);
    check("sim_cursor_held", int'(cursor), 1);
    btn_next = 1'b0; btn_confirm = 1'b0;
    cyc(2);
    board[1:0] = 2'b10;
    cyc(2);
    check("sim_turn", int'(turn), 0);
`ifdef TTT_AUTOSKIP_EN
    check("sim_cursor_after", int'(cursor), 2);
`else
    check("sim_cursor_after", int'(cursor), 1);
`endif
    check("sim_playO_once", seen_o - bo, 1);
    check("sim_no_playX", seen_x - bx, 0);
    cyc(DEB_CYCLES + 2);

    // Game ends while waiting for the ack
`ifndef TTT_AUTOSKIP_EN
    press_next();
`endif
    check("over_cursor2", int'(cursor), 2);
    btn_confirm = 1'b1;
    cyc(7);
    who = 2'b01;
    cyc(1);
    check("over_level", int'(game_over), 1);
    check("over_pos", int'(playerX_position), 0);
    check("over_strobe", int'(playX), 0);
    btn_confirm = 1'b0;
    cyc(DEB_CYCLES + 2);
    cur = int'(cursor); bx = seen_x + seen_o;
    press_next();
    press_conf();
    check("over_cursor_frozen", int'(cursor), cur);
    check("over_no_strobe", seen_x + seen_o - bx, 0);
    check("over_still", int'(game_over), 1);

    // Asynchronous reset in the middle of a move
    rst = 1'b1; board = '0; who = 2'b00;
    cyc(2);
    rst = 1'b0;
    cyc(2);
    btn_confirm = 1'b1;
    cyc(5);
    check("ar_pos_before", int'(playerX_position), 1);
    #2 rst = 1'b1;
    #1;
    check("ar_pos", int'(playerX_position), 0);
    check("ar_cursor", int'(cursor), 1);
    check("ar_turn", int'(turn), FIRST_PLAYER);
    check("ar_over", int'(game_over), 0);
    @(negedge clk);
    btn_confirm = 1'b0;
    cyc(1);
    rst = 1'b0;
    cyc(DEB_CYCLES + 2);

`ifdef TTT_AUTOSKIP_EN
    // Skip over occupied cells 1-3 from cursor 9
    repeat (8) press_next();
    check("skip_cursor9", int'(cursor), 9);
    board[5:0] = 6'b01_10_01;
    press_next();
    check("skip_cursor4", int'(cursor), 4);
`endif

    cyc(3);
    done = 1'b1;
  endtask

  initial begin
    n_cmp = 0; n_bad = 0;
    seen_x = 0; seen_o = 0; seen_eo = 0; seen_et = 0;
    done = 1'b0;
    fork
      compare_loop();
      stimulus();
    join
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete @%0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
